// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encodings, handshake
// levels, datapath widths and the conditional-negate helper.
package div_pkg;

    localparam int REGBUS       = 32;
    localparam int DOUBLEREGBUS = 64;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIVRESULTREADY    = 1'b1;
    localparam logic DIVRESULTNOTREADY = 1'b0;
    localparam logic DIVSTART          = 1'b1;
    localparam logic DIVSTOP           = 1'b0;

    // Two's-complement negate when neg is set; also serves as |x| for signed divides.
    function automatic logic [REGBUS-1:0] cond_neg(input logic [REGBUS-1:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration on the 65-bit {partial remainder, quotient} register.
module div_step
    import div_pkg::*;
(
    input  logic [64:0]       work_i,
    input  logic [REGBUS-1:0] divisor_i,
    output logic [64:0]       work_o
);

    // Shifted partial remainder (2*rem + next dividend bit) minus divisor; 34 bits
    // so divisors above 2^31 are still compared correctly.
    logic [33:0] diff;

    always_comb begin
        diff = work_i[64:31] - {2'b00, divisor_i};
        if (diff[33]) begin
            work_o = {work_i[63:0], 1'b0};
        end else begin
            work_o = {diff[32:0], work_i[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish on the accepting edge when |dividend| < |divisor|.
module div_iter
    import div_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    signed_div_i,
    input  logic [REGBUS-1:0]       opdata1_i,
    input  logic [REGBUS-1:0]       opdata2_i,
    input  logic                    start_i,
    input  logic                    annul_i,
    output logic [DOUBLEREGBUS-1:0] result_o,
    output logic                    ready_o
);

    div_state_e              state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [64:0]             work_q, work_d, work_step;
    logic [REGBUS-1:0]       divisor_q, divisor_d;
    logic                    neg_quot_q, neg_quot_d;
    logic                    neg_rem_q, neg_rem_d;
    logic [DOUBLEREGBUS-1:0] result_q, result_d;
    logic                    ready_q, ready_d;
    logic [REGBUS-1:0]       op1_abs, op2_abs;

    assign op1_abs = cond_neg(opdata1_i, signed_div_i & opdata1_i[31]);
    assign op2_abs = cond_neg(opdata2_i, signed_div_i & opdata2_i[31]);

    div_step u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (work_step)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;
        unique case (state_q)
            DIV_FREE: begin
                cnt_d    = '0;
                result_d = '0;
                ready_d  = DIVRESULTNOTREADY;
                if (start_i == DIVSTART && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
`ifdef DIV_EARLY_OUT_EN
                    end else if (op1_abs < op2_abs) begin
                        state_d  = DIV_END;
                        result_d = {opdata1_i, 32'd0};
                        ready_d  = DIVRESULTREADY;
`endif
                    end else begin
                        state_d    = DIV_ON;
                        work_d     = {33'd0, op1_abs};
                        divisor_d  = op2_abs;
                        neg_rem_d  = signed_div_i & opdata1_i[31];
                        neg_quot_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    end
                end
            end
            DIV_BYZERO: begin
                state_d  = DIV_END;
                result_d = '0;
                ready_d  = DIVRESULTREADY;
            end
            DIV_ON: begin
                // A flush wins over the iteration in progress.
                if (annul_i) begin
                    state_d = DIV_FREE;
                    ready_d = DIVRESULTNOTREADY;
                end else if (cnt_q != 6'd32) begin
                    work_d = work_step;
                    cnt_d  = cnt_q + 6'd1;
                end else begin
                    result_d = {cond_neg(work_q[63:32], neg_rem_q),
                                cond_neg(work_q[31:0], neg_quot_q)};
                    ready_d  = DIVRESULTREADY;
                    state_d  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIVSTOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIVRESULTNOTREADY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= DIVRESULTNOTREADY;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    // Datapath registers are only meaningful in DIV_ON and need no reset.
    always_ff @(posedge clk) begin
        work_q     <= work_d;
        divisor_q  <= divisor_d;
        neg_quot_q <= neg_quot_d;
        neg_rem_q  <= neg_rem_d;
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter; expectations queued at launch, checked at ready_o.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    function automatic logic [63:0] model_res(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sbv, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
        end else begin
            sa  = longint'({32'd0, a});
            sbv = longint'({32'd0, b});
        end
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] ma, mb;
        if (b == 32'd0) return 1;
        ma = (sgn && a[31]) ? 32'd0 - a : a;
        mb = (sgn && b[31]) ? 32'd0 - b : b;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 0;
`endif
        return (ma == mb) ? 33 : 33;
    endfunction

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] er, input int el);
        exp_t e;
        int   lat;
        e.res = er; e.lat = el; e.name = name;
        sb.push_back(e);
        signed_div = sgn; op1 = a; op2 = b; start = 1'b1;
        @(posedge clk); #1;
        op1 = $urandom; op2 = $urandom;
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: ready=%b required 1", e.name, ready);
        end
        total++;
        if (lat != e.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", e.name, lat, e.lat);
        end
        total++;
        if (result !== e.res) begin
            bad++;
            $display("FAIL %s result: got %h required %h", e.name, result, e.res);
        end
        annul = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        annul = 1'b0;
        total++;
        if (ready !== 1'b1 || result !== e.res) begin
            bad++;
            $display("FAIL %s hold: ready=%b result=%h required 1 %h", e.name, ready, result, e.res);
        end
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL %s release: ready=%b result=%h required 0 0", e.name, ready, result);
        end
    endtask

    task automatic watch_idle(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (ready !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL %s idle: ready rose, required to stay 0", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1; signed_div = 1'b0; op1 = 32'd10; op2 = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got %b required 0", ready);
        end
        total++;
        if (result !== 64'd0) begin
            bad++;
            $display("FAIL reset_result: got %h required 0", result);
        end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        do_div("u100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);
    endtask

    task automatic test_signed();
        do_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        do_div("s7_-2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33);
    endtask

    task automatic test_divzero();
        do_div("s5_0", 32'd5, 32'd0, 1'b1, 64'd0, 1);
        do_div("u5_0", 32'd5, 32'd0, 1'b0, 64'd0, 1);
    endtask

    task automatic test_annul();
        // annul in FREE must block acceptance
        signed_div = 1'b0; op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        watch_idle("annul_free", 40);
        // annul during iteration 10 of a long divide
        op1 = 32'hFFFF_FFFF; op2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL annul_on: ready=%b required 0", ready);
        end
        watch_idle("annul_on", 40);
        do_div("u9_3", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33);
    endtask

    task automatic test_overflow();
        do_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 33);
    endtask

    task automatic test_reset_mid();
        signed_div = 1'b1; op1 = 32'h8000_0000; op2 = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid: ready=%b result=%h required 0 0", ready, result);
        end
        rst = 1'b0; start = 1'b0;
        watch_idle("reset_mid", 40);
    endtask

    task automatic test_early();
`ifdef DIV_EARLY_OUT_EN
        do_div("s-3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, {32'hFFFF_FFFD, 32'd0}, 0);
`else
        do_div("s-3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, {32'hFFFF_FFFD, 32'd0}, 33);
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] av[6];
        logic [31:0] bv[6];
        logic        sv[6];
        av = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1234_5678, 32'h8765_4321, 32'hDEAD_BEEF, 32'd0};
        bv = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0123, 32'hFFFF_F00D, 32'h0000_0007, 32'd9};
        sv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            do_div($sformatf("b2b_%0d", i), av[i], bv[i], sv[i],
                   model_res(av[i], bv[i], sv[i]), model_lat(av[i], bv[i], sv[i]));
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            logic        s;
            a = $urandom; b = $urandom_range(1, 1000); s = i[0];
            do_div($sformatf("rnd_%0d", i), a, b, s, model_res(a, b, s), model_lat(a, b, s));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_overflow();
        test_reset_mid();
        test_early();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
